// File: rtl/fsm_prob_b_steer_arb_if.sv
// Requester-side and FSM-side signals of the fsm_prob_b steering arbiter.
// The slave modport is the arbiter; the master modport is requesters plus FSM.
interface fsm_prob_b_steer_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] tgt;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              fsm_i;
  logic              fsm_j;
  logic              fsm_x;
  logic              fsm_y;
  logic              err;

  modport master (
    output req, tgt, fsm_x, fsm_y,
    input  gnt, done, busy, fsm_i, fsm_j, err
  );

  modport slave (
    input  req, tgt, fsm_x, fsm_y,
    output gnt, done, busy, fsm_i, fsm_j, err
  );
endinterface

// File: rtl/fsm_prob_b_steer_arb.sv
// Round-robin arbiter that shares the fsm_prob_b Moore FSM among NREQ requesters,
// steering it to each requested state along the shortest path via a shadow model.
module fsm_prob_b_steer_arb #(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  fsm_prob_b_steer_arb_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_A = 2'd0, ST_B = 2'd1, ST_C = 2'd2, ST_D = 2'd3} fsm_st_e;
  typedef enum logic {IDLE = 1'b0, STEER = 1'b1} ctl_e;

  ctl_e          ctl_q, ctl_d;
  fsm_st_e       mstate_q, mstate_d;
  fsm_st_e       target_q, target_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          err_q, err_d;

  logic          pick_vld;
  logic [PW-1:0] pick_idx;
  logic          steering;
  logic [1:0]    ij;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;

  // {i,j} that moves the FSM one hop along the shortest path from cur to tgt.
  function automatic logic [1:0] step(input fsm_st_e cur, input fsm_st_e tgt);
    logic [1:0] r;
    r = 2'b00;
    unique case (cur)
      ST_A: r = (tgt == ST_A) ? 2'b00 : 2'b10;
      ST_B: r = (tgt == ST_B || tgt == ST_C) ? 2'b10 : 2'b00;
      ST_C: r = (tgt == ST_B) ? 2'b10 : (tgt == ST_C) ? 2'b01 : 2'b00;
      ST_D: r = (tgt == ST_A) ? 2'b00 : (tgt == ST_D) ? 2'b10 : 2'b01;
    endcase
    return r;
  endfunction

  function automatic fsm_st_e fsm_next(input fsm_st_e cur, input logic i, input logic j);
    fsm_st_e n;
    n = cur;
    unique case (cur)
      ST_A: n = i ? ST_B : ST_A;
      ST_B: n = i ? ST_C : ST_D;
      ST_C: n = i ? ST_B : (j ? ST_C : ST_D);
      ST_D: n = i ? ST_D : (j ? ST_C : ST_A);
    endcase
    return n;
  endfunction

  function automatic logic [1:0] exp_xy(input fsm_st_e cur);
    logic [1:0] r;
    r = 2'b10;
    unique case (cur)
      ST_A: r = 2'b11;
      ST_B: r = 2'b01;
      ST_C: r = 2'b10;
      ST_D: r = 2'b10;
    endcase
    return r;
  endfunction

  // Scan from the far end back toward ptr so the nearest request at/after ptr wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_b;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    idx_b    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx   = (int'(ptr_q) + off) % NREQ;
      idx_b = PW'(idx);
      if (bus.req[idx_b]) begin
        pick_vld = 1'b1;
        pick_idx = idx_b;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    ctl_d    = ctl_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    steering = 1'b0;
    done     = '0;
    unique case (ctl_q)
      IDLE: begin
        if (pick_vld) begin
          ctl_d    = STEER;
          owner_d  = pick_idx;
          target_d = fsm_st_e'(bus.tgt[{pick_idx, 1'b0} +: 2]);
          ptr_d    = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        end
      end
      STEER: begin
        if (!bus.req[owner_q]) begin
          ctl_d = IDLE;
        end else if (mstate_q == target_q) begin
          ctl_d          = IDLE;
          done[owner_q]  = 1'b1;
        end else begin
          steering = 1'b1;
        end
      end
    endcase

    // Outside an active step (idle, abort, done cycle) the FSM is walked home to A.
    ij       = steering ? step(mstate_q, target_q) : step(mstate_q, ST_A);
    mstate_d = fsm_next(mstate_q, ij[1], ij[0]);
    err_d    = err_q | ({bus.fsm_x, bus.fsm_y} != exp_xy(mstate_q));
  end

  always_comb begin
    gnt = '0;
    if (ctl_q == STEER) gnt[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rstn) begin
      ctl_q    <= IDLE;
      mstate_q <= ST_A;
      target_q <= ST_A;
      ptr_q    <= '0;
      owner_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      mstate_q <= mstate_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt   = gnt;
  assign bus.done  = done;
  assign bus.busy  = |gnt;
  assign bus.fsm_i = ij[1];
  assign bus.fsm_j = ij[0];
  assign bus.err   = err_q;

endmodule
